typed_fifo: RTL and testbench

TYPED_FIFO -- requirements
Module: typed_fifo

---
 rtl/typed_fifo.sv | 122 ++++++++++++
 tb/tb_typed_fifo.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/typed_fifo.sv
// Synchronous FIFO with a parameterised entry type and non-power-of-two depth.
// With OUT_REG=1 the head entry is held in a register ahead of the memory.
module typed_fifo #(
  parameter type DATA_TYPE = logic [7:0],
  parameter int  DEPTH     = 8,
  parameter int  AF_LEVEL  = DEPTH - 2,
  parameter int  OUT_REG   = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  DATA_TYPE                     i_data,
  input  logic                         i_pop,
  output DATA_TYPE                     o_data,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("typed_fifo: DEPTH must be at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("typed_fifo: AF_LEVEL must lie in 1..DEPTH");
  end

  DATA_TYPE             mem_q [DEPTH];
  DATA_TYPE             out_data_q;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     mem_cnt;
  logic                 out_vld_q, out_vld_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 full;
  logic                 head_vld;
  logic                 push_acc, pop_acc;
  logic                 load, mem_rd;
  logic                 wr_en, load_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake decisions depend only on registered state plus the requests.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    head_vld = (OUT_REG != 0) ? out_vld_q : (count_q != '0);
    pop_acc  = i_pop && head_vld;
    push_acc = i_push && (!full || pop_acc);
    mem_cnt  = count_q - CNT_W'(out_vld_q);
    load     = (OUT_REG != 0) && (mem_cnt != '0) && (!out_vld_q || pop_acc);
    mem_rd   = (OUT_REG != 0) ? load : pop_acc;
  end

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    out_vld_d = out_vld_q;
    ovf_d     = 1'b0;
    udf_d     = 1'b0;
    wr_en     = 1'b0;
    load_en   = 1'b0;
    if (i_clear) begin
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      out_vld_d = 1'b0;
    end else begin
      wr_en   = push_acc && i_rst_n;
      load_en = load && i_rst_n;
      if (push_acc) wptr_d = ptr_inc(wptr_q);
      if (mem_rd)   rptr_d = ptr_inc(rptr_q);
      count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
      ovf_d   = i_push && !push_acc;
      udf_d   = i_pop && !pop_acc;
      if (OUT_REG != 0) out_vld_d = load || (out_vld_q && !pop_acc);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage and the head register carry no reset; validity lives in count/out_vld.
  always_ff @(posedge i_clk) begin
    if (wr_en)   mem_q[wptr_q] <= i_data;
    if (load_en) out_data_q    <= mem_q[rptr_q];
  end

  assign o_data        = (OUT_REG != 0) ? out_data_q : mem_q[rptr_q];
  assign o_empty       = !head_vld;
  assign o_full        = full;
  assign o_almost_full = (count_q >= CNT_W'(AF_LEVEL));
  assign o_count       = count_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = udf_q;

endmodule

// File: tb/tb_typed_fifo.sv
// Bench for typed_fifo: three configurations (struct/DEPTH4, byte/DEPTH5, byte/DEPTH8 registered head)
// checked by directed scenarios and by a queue-based reference model under random traffic.
module tb_typed_fifo;

  typedef struct packed { logic [3:0] a; logic b; } pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, clear;
  logic [2:0]      push, pop;
  logic [2:0][7:0] din;
  pair_t           s_din, s_dout;
  logic [7:0]      d_dout, r_dout;
  logic [2:0]      s_cnt, d_cnt;
  logic [3:0]      r_cnt;
  logic [2:0]      emp, ful, afl, ovf, udf;

  int n_chk = 0;
  int n_fail = 0;

  assign s_din = pair_t'(din[0][4:0]);

  typed_fifo #(.DATA_TYPE(pair_t), .DEPTH(4)) u_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_push(push[0]), .i_data(s_din),
    .i_pop(pop[0]), .o_data(s_dout), .o_empty(emp[0]), .o_full(ful[0]),
    .o_almost_full(afl[0]), .o_count(s_cnt), .o_overflow(ovf[0]), .o_underflow(udf[0]));

  typed_fifo #(.DATA_TYPE(logic [7:0]), .DEPTH(5)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_push(push[1]), .i_data(din[1]),
    .i_pop(pop[1]), .o_data(d_dout), .o_empty(emp[1]), .o_full(ful[1]),
    .o_almost_full(afl[1]), .o_count(d_cnt), .o_overflow(ovf[1]), .o_underflow(udf[1]));

  typed_fifo #(.DATA_TYPE(logic [7:0]), .DEPTH(8), .AF_LEVEL(6), .OUT_REG(1)) u_r (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_push(push[2]), .i_data(din[2]),
    .i_pop(pop[2]), .o_data(r_dout), .o_empty(emp[2]), .o_full(ful[2]),
    .o_almost_full(afl[2]), .o_count(r_cnt), .o_overflow(ovf[2]), .o_underflow(udf[2]));

  // Reference model: an entry becomes readable OUT_REG edges after the edge that stored it.
  int depth [3] = '{4, 5, 8};
  int aflv  [3] = '{2, 3, 6};
  int oreg  [3] = '{0, 0, 1};
  int qd [3][$];
  int qc [3][$];
  int ecyc = 0;
  bit [2:0] m_ovf = '0, m_udf = '0;

  function automatic bit m_vis(input int i);
    if (qd[i].size() == 0) return 1'b0;
    return (qc[i][0] + oreg[i] <= ecyc);
  endfunction

  task automatic model_step();
    int e;
    bit pa, qa;
    e = ecyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || clear) begin
        qd[i].delete();
        qc[i].delete();
        m_ovf[i] = 1'b0;
        m_udf[i] = 1'b0;
      end else begin
        pa = pop[i] && m_vis(i);
        qa = push[i] && (qd[i].size() < depth[i] || pa);
        m_ovf[i] = push[i] && !qa;
        m_udf[i] = pop[i] && !pa;
        if (pa) begin
          void'(qd[i].pop_front());
          void'(qc[i].pop_front());
        end
        if (qa) begin
          qd[i].push_back((i == 0) ? int'(din[i][4:0]) : int'(din[i]));
          qc[i].push_back(e);
        end
      end
    end
    ecyc = e;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    push = '0;
    pop = '0;
    clear = 1'b0;
  endtask

  function automatic logic [31:0] a_cnt(input int i);
    case (i)
      0: return {29'd0, s_cnt};
      1: return {29'd0, d_cnt};
      default: return {28'd0, r_cnt};
    endcase
  endfunction

  function automatic logic [31:0] a_dat(input int i);
    case (i)
      0: return {27'd0, s_dout};
      1: return {24'd0, d_dout};
      default: return {24'd0, r_dout};
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    din = '0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (a_cnt(i) !== 32'd0) begin n_fail++; $display("FAIL reset_count[%0d] got %0d want 0", i, a_cnt(i)); end
      n_chk++; if (emp[i] !== 1'b1) begin n_fail++; $display("FAIL reset_empty[%0d] got %b want 1", i, emp[i]); end
      n_chk++; if (ful[i] !== 1'b0) begin n_fail++; $display("FAIL reset_full[%0d] got %b want 0", i, ful[i]); end
      n_chk++; if (afl[i] !== 1'b0) begin n_fail++; $display("FAIL reset_afull[%0d] got %b want 0", i, afl[i]); end
      n_chk++; if (ovf[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ovf[%0d] got %b want 0", i, ovf[i]); end
      n_chk++; if (udf[i] !== 1'b0) begin n_fail++; $display("FAIL reset_udf[%0d] got %b want 0", i, udf[i]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_struct();
    logic [4:0] sv [4];
    sv = '{5'b1010_1, 5'b0011_0, 5'b1111_0, 5'b0001_1};
    for (int k = 0; k < 4; k++) begin
      push[0] = 1'b1;
      din[0] = {3'd0, sv[k]};
      tick();
    end
    push[0] = 1'b0;
    n_chk++; if (ful[0] !== 1'b1) begin n_fail++; $display("FAIL struct_full got %b want 1", ful[0]); end
    n_chk++; if (s_cnt !== 3'd4) begin n_fail++; $display("FAIL struct_count got %0d want 4", s_cnt); end
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (s_dout.a !== sv[k][4:1]) begin n_fail++; $display("FAIL struct_a[%0d] got %h want %h", k, s_dout.a, sv[k][4:1]); end
      n_chk++; if (s_dout.b !== sv[k][0]) begin n_fail++; $display("FAIL struct_b[%0d] got %b want %b", k, s_dout.b, sv[k][0]); end
      pop[0] = 1'b1;
      tick();
    end
    pop[0] = 1'b0;
    n_chk++; if (emp[0] !== 1'b1) begin n_fail++; $display("FAIL struct_empty got %b want 1", emp[0]); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp[$];
    logic [7:0] v;
    int pushed = 0;
    int popped = 0;
    for (int c = 0; c < 40 && popped < 12; c++) begin
      push[1] = (pushed < 12);
      pop[1]  = (d_cnt == 3'd5) || (pushed == 12 && emp[1] == 1'b0);
      if (pop[1]) begin
        n_chk++; if (d_dout !== exp[0]) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", popped, d_dout, exp[0]); end
        void'(exp.pop_front());
        popped++;
      end
      if (push[1]) begin
        v = 8'($urandom);
        din[1] = v;
        exp.push_back(v);
        pushed++;
      end
      tick();
      n_chk++; if (d_cnt > 3'd5 || 32'(d_cnt) !== 32'(exp.size())) begin n_fail++; $display("FAIL wrap_count got %0d want %0d", d_cnt, exp.size()); end
    end
    idle_all();
    n_chk++; if (popped != 12) begin n_fail++; $display("FAIL wrap_popped got %0d want 12", popped); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp[$];
    for (int k = 0; k < 5; k++) begin
      push[1] = 1'b1;
      din[1] = 8'h10 + 8'(k);
      exp.push_back(8'h10 + 8'(k));
      tick();
    end
    n_chk++; if (ful[1] !== 1'b1 || d_cnt !== 3'd5) begin n_fail++; $display("FAIL full_fill got full=%b count=%0d want 1/5", ful[1], d_cnt); end
    pop[1] = 1'b1;
    din[1] = 8'h20;
    void'(exp.pop_front());
    exp.push_back(8'h20);
    tick();
    n_chk++; if (d_cnt !== 3'd5) begin n_fail++; $display("FAIL full_pp_count got %0d want 5", d_cnt); end
    n_chk++; if (ovf[1] !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovf got %b want 0", ovf[1]); end
    pop[1] = 1'b0;
    din[1] = 8'hEE;
    tick();
    push[1] = 1'b0;
    n_chk++; if (ovf[1] !== 1'b1) begin n_fail++; $display("FAIL full_ovf got %b want 1", ovf[1]); end
    n_chk++; if (d_cnt !== 3'd5) begin n_fail++; $display("FAIL full_ovf_count got %0d want 5", d_cnt); end
    tick();
    n_chk++; if (ovf[1] !== 1'b0) begin n_fail++; $display("FAIL full_ovf_clear got %b want 0", ovf[1]); end
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (d_dout !== exp[k]) begin n_fail++; $display("FAIL full_drain[%0d] got %h want %h", k, d_dout, exp[k]); end
      pop[1] = 1'b1;
      tick();
    end
    pop[1] = 1'b0;
    n_chk++; if (emp[1] !== 1'b1) begin n_fail++; $display("FAIL full_drain_empty got %b want 1", emp[1]); end
  endtask

  task automatic test_empty_pushpop();
    push[1] = 1'b1;
    pop[1] = 1'b1;
    din[1] = 8'h5A;
    tick();
    idle_all();
    n_chk++; if (udf[1] !== 1'b1) begin n_fail++; $display("FAIL epp_udf got %b want 1", udf[1]); end
    n_chk++; if (d_cnt !== 3'd1) begin n_fail++; $display("FAIL epp_count got %0d want 1", d_cnt); end
    n_chk++; if (d_dout !== 8'h5A) begin n_fail++; $display("FAIL epp_data got %h want 5a", d_dout); end
    tick();
    n_chk++; if (udf[1] !== 1'b0) begin n_fail++; $display("FAIL epp_udf_clear got %b want 0", udf[1]); end
    pop[1] = 1'b1;
    tick();
    pop[1] = 1'b0;
    n_chk++; if (emp[1] !== 1'b1) begin n_fail++; $display("FAIL epp_empty got %b want 1", emp[1]); end
  endtask

  task automatic test_clear_reset();
    for (int k = 0; k < 3; k++) begin
      push[1] = 1'b1;
      din[1] = 8'hA0 + 8'(k);
      tick();
    end
    n_chk++; if (d_cnt !== 3'd3) begin n_fail++; $display("FAIL clr_pre_count got %0d want 3", d_cnt); end
    clear = 1'b1;
    din[1] = 8'h77;
    tick();
    idle_all();
    n_chk++; if (d_cnt !== 3'd0) begin n_fail++; $display("FAIL clr_count got %0d want 0", d_cnt); end
    n_chk++; if (emp[1] !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %b want 1", emp[1]); end
    n_chk++; if (ovf[1] !== 1'b0 || udf[1] !== 1'b0) begin n_fail++; $display("FAIL clr_pulses got ovf=%b udf=%b want 0/0", ovf[1], udf[1]); end
    push[1] = 1'b1;
    din[1] = 8'h33;
    tick();
    n_chk++; if (d_dout !== 8'h33 || d_cnt !== 3'd1) begin n_fail++; $display("FAIL clr_after got data=%h count=%0d want 33/1", d_dout, d_cnt); end
    din[1] = 8'h34;
    tick();
    rst_n = 1'b0;
    din[1] = 8'h35;
    pop[1] = 1'b1;
    tick();
    rst_n = 1'b1;
    idle_all();
    n_chk++; if (d_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count got %0d want 0", d_cnt); end
    n_chk++; if (emp[1] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty got %b want 1", emp[1]); end
    n_chk++; if (ovf[1] !== 1'b0 || udf[1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulses got ovf=%b udf=%b want 0/0", ovf[1], udf[1]); end
  endtask

  task automatic test_outreg();
    logic [7:0] exp[$];
    int popped = 0;
    for (int k = 0; k < 8; k++) begin
      push[2] = 1'b1;
      din[2] = 8'hC0 + 8'(k);
      exp.push_back(8'hC0 + 8'(k));
      tick();
      if (k == 0) begin
        n_chk++; if (emp[2] !== 1'b1 || r_cnt !== 4'd1) begin n_fail++; $display("FAIL oreg_lat1 got empty=%b count=%0d want 1/1", emp[2], r_cnt); end
      end
      if (k == 1) begin
        n_chk++; if (emp[2] !== 1'b0 || r_dout !== 8'hC0) begin n_fail++; $display("FAIL oreg_lat2 got empty=%b data=%h want 0/c0", emp[2], r_dout); end
      end
      if (k == 4) begin
        n_chk++; if (afl[2] !== 1'b0) begin n_fail++; $display("FAIL oreg_af5 got %b want 0", afl[2]); end
      end
      if (k == 5) begin
        n_chk++; if (afl[2] !== 1'b1 || r_cnt !== 4'd6) begin n_fail++; $display("FAIL oreg_af6 got af=%b count=%0d want 1/6", afl[2], r_cnt); end
      end
    end
    n_chk++; if (ful[2] !== 1'b1 || r_cnt !== 4'd8) begin n_fail++; $display("FAIL oreg_full got full=%b count=%0d want 1/8", ful[2], r_cnt); end
    din[2] = 8'hFF;
    tick();
    push[2] = 1'b0;
    n_chk++; if (ovf[2] !== 1'b1) begin n_fail++; $display("FAIL oreg_ovf got %b want 1", ovf[2]); end
    for (int c = 0; c < 20 && popped < 8; c++) begin
      pop[2] = !emp[2];
      if (pop[2]) begin
        n_chk++; if (r_dout !== exp[popped]) begin n_fail++; $display("FAIL oreg_drain[%0d] got %h want %h", popped, r_dout, exp[popped]); end
        popped++;
      end
      tick();
    end
    pop[2] = 1'b0;
    n_chk++; if (popped != 8 || emp[2] !== 1'b1) begin n_fail++; $display("FAIL oreg_drain_end got popped=%0d empty=%b want 8/1", popped, emp[2]); end
  endtask

  task automatic test_random();
    int pr, qr;
    bit e_emp;
    for (int c = 0; c < 900; c++) begin
      pr = (c < 300) ? 75 : (c < 600) ? 30 : 55;
      qr = 100 - pr;
      for (int i = 0; i < 3; i++) begin
        push[i] = ($urandom_range(0, 99) < pr);
        pop[i]  = ($urandom_range(0, 99) < qr);
        din[i]  = 8'($urandom);
      end
      clear = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        e_emp = !m_vis(i);
        n_chk++; if (a_cnt(i) !== 32'(qd[i].size())) begin n_fail++; $display("FAIL rnd_count[%0d] c=%0d got %0d want %0d", i, c, a_cnt(i), qd[i].size()); end
        n_chk++; if (emp[i] !== e_emp) begin n_fail++; $display("FAIL rnd_empty[%0d] c=%0d got %b want %b", i, c, emp[i], e_emp); end
        n_chk++; if (ful[i] !== (qd[i].size() == depth[i])) begin n_fail++; $display("FAIL rnd_full[%0d] c=%0d got %b", i, c, ful[i]); end
        n_chk++; if (afl[i] !== (qd[i].size() >= aflv[i])) begin n_fail++; $display("FAIL rnd_afull[%0d] c=%0d got %b", i, c, afl[i]); end
        n_chk++; if (ovf[i] !== m_ovf[i]) begin n_fail++; $display("FAIL rnd_ovf[%0d] c=%0d got %b want %b", i, c, ovf[i], m_ovf[i]); end
        n_chk++; if (udf[i] !== m_udf[i]) begin n_fail++; $display("FAIL rnd_udf[%0d] c=%0d got %b want %b", i, c, udf[i], m_udf[i]); end
        if (!e_emp) begin
          n_chk++; if (a_dat(i) !== 32'(qd[i][0])) begin n_fail++; $display("FAIL rnd_data[%0d] c=%0d got %h want %h", i, c, a_dat(i), qd[i][0]); end
        end
      end
    end
    rst_n = 1'b1;
    idle_all();
    tick();
  endtask

  initial begin
    test_reset();
    test_struct();
    test_wrap();
    test_full_pushpop();
    test_empty_pushpop();
    test_clear_reset();
    test_outreg();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
